// File: rtl/pmem_responder_if.sv
// -----------------------------------------------------------------------------
// pmem_responder_if
//
// Request/response bundle between a core-side requester and pmem_responder.
//
// Request channel (valid/ready, requester -> responder):
//   req_valid  request present
//   req_ready  responder can accept a request this cycle
//   req_addr   byte address (bits [1:0] ignored for word indexing)
//   req_wen    1 = write, 0 = read
//   req_wdata  lane-aligned write data
//   req_wmask  byte enables, bit i covers req_wdata[8i+7:8i]
//
// Response channel (valid/ready, responder -> requester):
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  read data; zero for writes and errors
//   rsp_err    address fell outside the mapped window
//
// Modports: master = requester side, slave = responder side.
// -----------------------------------------------------------------------------
interface pmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pmem_responder.sv
// -----------------------------------------------------------------------------
// pmem_responder
//
// Memory-side responder for the core's load/store/fetch path. Accepts one
// request at a time, performs it against an internal word-organised RAM with
// byte write enables after a fixed latency, and holds the response until the
// requester takes it.
//
// Parameters:
//   BASE_ADDR    byte address mapped to RAM word 0
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, >= 2)
//   LATENCY      cycles from request acceptance to rsp_valid (>= 1)
//
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  synchronous active-high reset
//   bus  pmem_responder_if.slave request/response channels
//
// RAM contents are not reset; a reset abandons any in-flight request without
// committing it but leaves previously committed writes intact.
// -----------------------------------------------------------------------------
module pmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             rst,
  pmem_responder_if.slave bus
);

  localparam int unsigned   AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned   CW       = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [31:0]   SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  // With a one-cycle latency the access happens on the accepting edge itself,
  // so it must be fed straight from the request channel.
  localparam bit            DIRECT   = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic          wen_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          rd_ok_q;     // response carries RAM read data

  logic          req_ready;
  logic          req_fire;

  logic          acc_fire;
  logic [31:0]   acc_addr;
  logic          acc_wen;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wmask;
  logic [31:0]   acc_off;
  logic          acc_in_range;
  logic [AW-1:0] acc_idx;
  logic          acc_wr;
  logic          acc_rd;
  logic [31:0]   ram_rdata;

  // Gated by rst so the requester never sees ready during reset.
  assign req_ready = (state_q == IDLE) && !rst;
  assign req_fire  = req_ready && bus.req_valid;

  // Select the access source and the access strobe. rst blocks the strobe so
  // a request abandoned in BUSY never reaches the RAM.
  always_comb begin
    acc_addr  = addr_q;
    acc_wen   = wen_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    acc_fire  = (state_q == BUSY) && (cnt_q == CW'(1)) && !rst;
    if (DIRECT) begin
      acc_addr  = bus.req_addr;
      acc_wen   = bus.req_wen;
      acc_wdata = bus.req_wdata;
      acc_wmask = bus.req_wmask;
      acc_fire  = req_fire;
    end
  end

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far above
  // SPAN and are reported as errors.
  assign acc_off      = acc_addr - BASE_ADDR;
  assign acc_in_range = (acc_off < SPAN);
  assign acc_idx      = acc_off[AW+1:2];
  assign acc_wr       = acc_fire && acc_in_range && acc_wen;
  assign acc_rd       = acc_fire && acc_in_range && !acc_wen;

  // One byte-wide RAM per lane: each lane has its own write enable and a
  // registered read port, which maps onto byte-enabled block RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH_WORDS];
      logic [7:0] lane_rdata_q;

      always_ff @(posedge clk) begin
        if (acc_wr && acc_wmask[gi]) begin
          mem_q[acc_idx] <= acc_wdata[8*gi +: 8];
        end
        if (acc_rd) begin
          lane_rdata_q <= mem_q[acc_idx];
        end
      end

      assign ram_rdata[8*gi +: 8] = lane_rdata_q;
    end
  endgenerate

  // Control FSM. Response flags are captured on the edge that enters RESP and
  // held there until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            addr_q  <= bus.req_addr;
            wen_q   <= bus.req_wen;
            wdata_q <= bus.req_wdata;
            wmask_q <= bus.req_wmask;
            cnt_q   <= CNT_LOAD;
            if (DIRECT) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= !acc_in_range;
              rd_ok_q     <= acc_in_range && !acc_wen;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (acc_fire) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !acc_in_range;
            rd_ok_q     <= acc_in_range && !acc_wen;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The lane read registers only load on a read access, so they stay stable
  // through RESP; rd_ok_q masks them to zero for writes, errors and idle.
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rd_ok_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_pmem_responder.sv
// -----------------------------------------------------------------------------
// tb_pmem_responder
//
// Self-checking bench for pmem_responder. A LATENCY=2 instance takes directed
// and random traffic checked against a word-array model of the address map;
// a LATENCY=1 instance checks back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_pmem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  // Reference image of the mapped window, one entry per word.
  logic [31:0] model [DEPTH];

  pmem_responder_if bus ();
  pmem_responder_if bus1 ();

  pmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_eq("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check_eq("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
  endtask

  // One complete transaction on the LATENCY=2 instance. Expected results come
  // from the address-map rules applied to the model array.
  task automatic do_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                        input logic [3:0] wmask, input int hold,
                        output logic [31:0] rd, output logic err);
    logic [31:0] off;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          idx;
    int          acc;
    off     = addr - BASE;
    exp_err = (off >= SPAN);
    exp_rd  = 32'h0;
    idx     = int'(off >> 2);
    if (!exp_err && !wen) exp_rd = model[idx];
    if (!exp_err && wen) begin
      for (int i = 0; i < 4; i++)
        if (wmask[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
    end

    bus.req_addr  = addr;
    bus.req_wen   = wen;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    bus.req_valid = 1'b1;
    wait_ready();
    acc = cyc;
    tick();
    bus.req_valid = 1'b0;
    check_eq("busy_not_ready", 32'(bus.req_ready), 32'd0);
    wait_rsp();
    check_eq("latency", 32'(cyc - acc), 32'(LAT));
    rd  = bus.rsp_rdata;
    err = bus.rsp_err;
    check_eq("rsp_rdata", rd, exp_rd);
    check_eq("rsp_err", 32'(err), 32'(exp_err));
    repeat (hold) begin
      tick();
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_rdata", bus.rsp_rdata, exp_rd);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check_eq("rsp_clear", bus.rsp_rdata, 32'h0);
    n_txn++;
    $display("txn %0d %s addr=%h wdata=%h wmask=%b -> rdata=%h err=%b", n_txn,
             wen ? "WR" : "RD", addr, wdata, wmask, rd, err);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] prior;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] l1_data [4];
    int          last_acc;
    int          n;
    int          w;

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0;
    bus.req_wdata = '0;   bus.req_wmask = '0; bus.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_wen = 1'b0;
    bus1.req_wdata = '0;   bus1.req_wmask = '0; bus1.rsp_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst_l1_ready", 32'(bus1.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("idle_ready", 32'(bus.req_ready), 32'd1);
    check_eq("idle_l1_ready", 32'(bus1.req_ready), 32'd1);

    // Preload the words the random phase uses, plus the last word.
    for (int i = 0; i < 64; i++) do_txn(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 0, rd, er);
    do_txn(BASE + SPAN - 32'd4, 1'b1, $urandom, 4'hF, 0, rd, er);

    // Full write then readback
    do_txn(BASE + 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, rd, er);
    check_eq("tp_wr_rdata", rd, 32'h0);
    check_eq("tp_wr_err", 32'(er), 32'd0);
    do_txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("tp_rd_full", rd, 32'hDEADBEEF);

    // Partial write of lane 1
    do_txn(BASE + 32'h10, 1'b1, 32'h0000_AA00, 4'b0010, 0, rd, er);
    do_txn(BASE + 32'h10, 0, 32'h0, 4'h0, 0, rd, er);
    check_eq("tp_rd_partial", rd, 32'hDEADAAEF);

    // No-op write leaves the word alone
    do_txn(BASE + 32'h10, 1'b1, 32'h1234_5678, 4'b0000, 0, rd, er);
    do_txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("tp_rd_noop", rd, 32'hDEADAAEF);

    // Out-of-range on both sides of the window
    do_txn(BASE, 1'b1, 32'h1122_3344, 4'hF, 0, rd, er);
    do_txn(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("oor_low_err", 32'(er), 32'd1);
    check_eq("oor_low_rdata", rd, 32'h0);
    do_txn(32'h8000_1000, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("oor_high_err", 32'(er), 32'd1);
    check_eq("oor_high_rdata", rd, 32'h0);
    do_txn(32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    check_eq("oor_wr_err", 32'(er), 32'd1);
    do_txn(BASE, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("oor_word0", rd, 32'h1122_3344);
    do_txn(BASE + SPAN - 32'd1, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("edge_last_err", 32'(er), 32'd0);

    // Back-pressure with a pending request behind the response
    prior = model[4];
    bus.req_addr = BASE + 32'h10; bus.req_wen = 1'b0; bus.req_wmask = 4'h0;
    bus.req_valid = 1'b1;
    wait_ready();
    tick();
    bus.req_addr = BASE + 32'h30; bus.req_wen = 1'b1;
    bus.req_wdata = 32'hCAFE_F00D; bus.req_wmask = 4'hF;
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("bp_rdata", bus.rsp_rdata, prior);
      check_eq("bp_err", 32'(bus.rsp_err), 32'd0);
      check_eq("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check_eq("bp_drop", 32'(bus.rsp_valid), 32'd0);
    check_eq("bp_idle_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check_eq("bp_accepted", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    model[12] = 32'hCAFE_F00D;
    wait_rsp();
    check_eq("bp_wr_rdata", bus.rsp_rdata, 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    $display("txn bp: read %h held 5 cycles, pending write %h accepted after handshake",
             BASE + 32'h10, BASE + 32'h30);
    do_txn(BASE + 32'h30, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("bp_readback", rd, 32'hCAFE_F00D);

    // Reset while a write sits in BUSY
    prior = model[8];
    bus.req_addr = BASE + 32'h20; bus.req_wen = 1'b1;
    bus.req_wdata = ~prior; bus.req_wmask = 4'hF; bus.req_valid = 1'b1;
    wait_ready();
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_idle", 32'(bus.req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check_eq("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    $display("txn rst: write to %h abandoned in BUSY", BASE + 32'h20);
    do_txn(BASE + 32'h20, 1'b0, 32'h0, 4'h0, 0, rd, er);
    check_eq("mid_rst_prior", rd, prior);

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 6) == 0) begin
        case ($urandom_range(0, 2))
          0: a = BASE - 32'd1 - 32'($urandom_range(0, 255));
          1: a = BASE + SPAN + 32'($urandom_range(0, 4095));
          default: begin
            a = $urandom;
            d = a - BASE;
            while (d < SPAN) begin
              a = $urandom;
              d = a - BASE;
            end
          end
        endcase
      end else begin
        w = ($urandom_range(0, 9) == 0) ? DEPTH - 1 : int'($urandom_range(0, 63));
        a = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
      end
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), rd, er);
    end

    // LATENCY=1 instance: back-to-back writes then reads with rsp_ready held
    for (int i = 0; i < 4; i++) l1_data[i] = $urandom;
    bus1.rsp_ready = 1'b1;
    last_acc = 0;
    for (int k = 0; k < 8; k++) begin
      bus1.req_addr  = BASE + 32'(4 * (k % 4));
      bus1.req_wen   = (k < 4);
      bus1.req_wdata = l1_data[k % 4];
      bus1.req_wmask = 4'hF;
      bus1.req_valid = 1'b1;
      n = 0;
      while (bus1.req_ready !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      check_eq("l1_ready", 32'(bus1.req_ready), 32'd1);
      if (k > 0) check_eq("l1_interval", 32'(cyc - last_acc), 32'd2);
      last_acc = cyc;
      tick();
      check_eq("l1_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
      check_eq("l1_not_ready", 32'(bus1.req_ready), 32'd0);
      check_eq("l1_rdata", bus1.rsp_rdata, (k < 4) ? 32'h0 : l1_data[k % 4]);
      check_eq("l1_err", 32'(bus1.rsp_err), 32'd0);
      $display("txn l1 %0d %s addr=%h rdata=%h", k, (k < 4) ? "WR" : "RD",
               bus1.req_addr, bus1.rsp_rdata);
      tick();
      check_eq("l1_rsp_drop", 32'(bus1.rsp_valid), 32'd0);
    end
    bus1.req_valid = 1'b0;
    bus1.rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
